// File: rtl/reg_bank_ops_if.sv
// Handshake, operand and read-port bundle for reg_bank_ops.
// The master drives ops and read addresses; the slave is the register bank.
interface reg_bank_ops_if #(
    parameter int WIDTH = 8,
    parameter int NREG  = 8
);
    localparam int AW = $clog2(NREG);

    logic [2:0]       op;
    logic             op_valid;
    logic             op_ready;
    logic [AW-1:0]    addr_a;
    logic [AW-1:0]    addr_b;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output op, op_valid, addr_a, addr_b, wdata, rd_addr,
        input  op_ready, rd_data, busy, done, ovf
    );

    modport slave (
        input  op, op_valid, addr_a, addr_b, wdata, rd_addr,
        output op_ready, rd_data, busy, done, ovf
    );
endinterface

// File: rtl/reg_bank_ops.sv
// Parametrised scratch register bank with whole-bank ops (write/swap/rotate/add/reverse/sort).
// Define REG_BANK_OVF_EN to make ADD saturate and drive a sticky ovf flag.
module reg_bank_ops #(
    parameter int WIDTH = 8,
    parameter int NREG  = 8
) (
    input  logic          clk,
    input  logic          rst,
    reg_bank_ops_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] LAST = AW'(NREG - 2);
    localparam logic [AW-1:0] TOP  = AW'(NREG - 1);
    localparam logic [AW-1:0] HALF = AW'(NREG / 2 - 1);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_WR   = 3'b001;
    localparam logic [2:0] OP_SWAP = 3'b010;
    localparam logic [2:0] OP_RUP  = 3'b011;
    localparam logic [2:0] OP_RDN  = 3'b100;
    localparam logic [2:0] OP_ADD  = 3'b101;
    localparam logic [2:0] OP_REV  = 3'b110;
    localparam logic [2:0] OP_SORT = 3'b111;

    typedef enum logic [1:0] {IDLE, REV, SORT} state_t;

    state_t           state;
    logic [WIDTH-1:0] regs [NREG];
    logic [AW-1:0]    idx;
    logic [AW-1:0]    pass;
    logic             swapped;
    logic             done_q;

    logic             a_ok, b_ok, rd_ok;
    logic [AW-1:0]    idx_n, mirror;
    logic             gt;

    // Non-power-of-two depths leave unused address codes; those act as holes.
    assign a_ok   = 32'(bus.addr_a)  < NREG;
    assign b_ok   = 32'(bus.addr_b)  < NREG;
    assign rd_ok  = 32'(bus.rd_addr) < NREG;
    assign idx_n  = idx + 1'b1;
    assign mirror = TOP - idx;
    assign gt     = regs[idx] > regs[idx_n];

    assign bus.rd_data  = rd_ok ? regs[bus.rd_addr] : '0;
    assign bus.op_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;

`ifdef REG_BANK_OVF_EN
    logic             ovf_q;
    logic [WIDTH:0]   sum;
    assign sum     = {1'b0, regs[bus.addr_a]} + {1'b0, regs[bus.addr_b]};
    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            state   <= IDLE;
            idx     <= '0;
            pass    <= '0;
            swapped <= 1'b0;
            done_q  <= 1'b0;
`ifdef REG_BANK_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.op_valid) begin
                    done_q <= 1'b1;
                    case (bus.op)
                        OP_NOP: ;
                        OP_WR: if (a_ok) regs[bus.addr_a] <= bus.wdata;
                        OP_SWAP: if (a_ok && b_ok) begin
                            regs[bus.addr_a] <= regs[bus.addr_b];
                            regs[bus.addr_b] <= regs[bus.addr_a];
                        end
                        OP_RUP:
                            for (int i = 0; i < NREG; i++) regs[i] <= regs[(i + NREG - 1) % NREG];
                        OP_RDN:
                            for (int i = 0; i < NREG; i++) regs[i] <= regs[(i + 1) % NREG];
                        OP_ADD: if (a_ok && b_ok) begin
`ifdef REG_BANK_OVF_EN
                            if (sum[WIDTH]) begin
                                regs[bus.addr_a] <= '1;
                                ovf_q            <= 1'b1;
                            end else begin
                                regs[bus.addr_a] <= sum[WIDTH-1:0];
                            end
`else
                            regs[bus.addr_a] <= regs[bus.addr_a] + regs[bus.addr_b];
`endif
                        end
                        OP_REV: begin
                            done_q <= 1'b0;
                            idx    <= '0;
                            state  <= REV;
                        end
                        OP_SORT: begin
                            done_q  <= 1'b0;
                            idx     <= '0;
                            pass    <= '0;
                            swapped <= 1'b0;
                            state   <= SORT;
                        end
                        default: ;
                    endcase
                end
                REV: begin
                    regs[idx]    <= regs[mirror];
                    regs[mirror] <= regs[idx];
                    idx          <= idx_n;
                    if (idx == HALF) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                SORT: begin
                    if (gt) begin
                        regs[idx]   <= regs[idx_n];
                        regs[idx_n] <= regs[idx];
                    end
                    // Pass p ends at j = NREG-2-p; a clean pass or the final pass finishes.
                    if (idx == LAST - pass) begin
                        if (!(swapped || gt) || pass == LAST) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            pass    <= pass + 1'b1;
                            idx     <= '0;
                            swapped <= 1'b0;
                        end
                    end else begin
                        idx     <= idx_n;
                        swapped <= swapped | gt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_bank_ops.sv
// Randomised self-checking bench for reg_bank_ops against a whole-op behavioural model.
module tb_reg_bank_ops;
    localparam int W  = 8;
    localparam int N  = 8;
    localparam int AW = $clog2(N);
`ifdef REG_BANK_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // Model: final bank contents, remaining busy cycles, done and ovf expectations.
    int m [N];
    int m_left = 0;
    bit m_done = 1'b0;
    bit m_ovf  = 1'b0;

    reg_bank_ops_if #(.WIDTH(W), .NREG(N)) bus();

    reg_bank_ops #(.WIDTH(W), .NREG(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #50 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m[i] = 0;
        m_left = 0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // Applies a whole op to the model at once; returns how many busy cycles it costs.
    task automatic model_apply(input int op, input int a, input int b, input int wd, output int dur);
        int tmp [N];
        int s, t;
        bit sw;
        dur = 0;
        for (int i = 0; i < N; i++) tmp[i] = m[i];
        case (op)
            1: if (a < N) m[a] = wd;
            2: if (a < N && b < N) begin t = m[a]; m[a] = m[b]; m[b] = t; end
            3: for (int i = 0; i < N; i++) m[i] = tmp[(i + N - 1) % N];
            4: for (int i = 0; i < N; i++) m[i] = tmp[(i + 1) % N];
            5: if (a < N && b < N) begin
                s = m[a] + m[b];
                if (OVF_EN && s >= (1 << W)) begin
                    m[a]  = (1 << W) - 1;
                    m_ovf = 1'b1;
                end else begin
                    m[a] = s % (1 << W);
                end
            end
            6: begin
                for (int i = 0; i < N / 2; i++) m[i] = tmp[N - 1 - i];
                for (int i = N / 2; i < N; i++) m[i] = tmp[N - 1 - i];
                dur = N / 2;
            end
            7: for (int p = 0; p <= N - 2; p++) begin
                sw = 1'b0;
                for (int j = 0; j <= N - 2 - p; j++) begin
                    dur++;
                    if (m[j] > m[j + 1]) begin t = m[j]; m[j] = m[j + 1]; m[j + 1] = t; sw = 1'b1; end
                end
                if (!sw) break;
            end
            default: ;
        endcase
    endtask

    task automatic model_step();
        int dur;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
        end else if (bus.op_valid) begin
            model_apply(int'(bus.op), int'(bus.addr_a), int'(bus.addr_b), int'(bus.wdata), dur);
            m_left = dur;
            m_done = (dur == 0);
        end else begin
            m_done = 1'b0;
        end
    endtask

    task automatic compare();
        chk("op_ready", bus.op_ready, 32'(m_left == 0));
        chk("busy", bus.busy, 32'(m_left != 0));
        chk("done", bus.done, 32'(m_done));
        chk("ovf", bus.ovf, 32'(m_ovf));
        if (m_left == 0) chk("rd_data", bus.rd_data, m[bus.rd_addr]);
    endtask

    task automatic tick();
        bus.rd_addr = AW'($urandom_range(0, N - 1));
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_op(input int op, input int a, input int b, input int wd);
        bus.op       = 3'(op);
        bus.addr_a   = AW'(a);
        bus.addr_b   = AW'(b);
        bus.wdata    = W'(wd);
        bus.op_valid = 1'b1;
        tick();
        bus.op_valid = 1'b0;
    endtask

    // Runs until the DUT drops busy; optionally hammers a WRITE r0=99 meanwhile.
    task automatic wait_idle(input bit inject, output int nb, output int nd);
        int guard = 0;
        nb = int'(bus.busy);
        nd = 0;
        while (bus.busy && guard < 200) begin
            if (inject) begin
                bus.op = 3'd1; bus.addr_a = '0; bus.wdata = 8'd99; bus.op_valid = 1'b1;
            end
            tick();
            guard++;
            nb += int'(bus.busy);
            nd += int'(bus.done);
        end
        bus.op_valid = 1'b0;
        if (guard >= 200) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles", bus.busy, guard);
        end
    endtask

    task automatic rd_chk(input int idx, input int exp);
        bus.rd_addr = AW'(idx);
        #1;
        chk("rd_lit", bus.rd_data, exp);
        chk("model_lit", m[idx], exp);
    endtask

    task automatic preload(input int v0, input int step);
        for (int i = 0; i < N; i++) do_op(1, i, 0, (v0 + step * i) & 255);
    endtask

    initial begin
        int nb, nd;
        bus.op = '0; bus.op_valid = 1'b0; bus.addr_a = '0; bus.addr_b = '0;
        bus.wdata = '0; bus.rd_addr = '0;
        model_reset();
        tick();
        tick();
        chk("rst_ready", bus.op_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst = 1'b0;

        // Preload 0,7,6,...,1 then SORT.
        do_op(1, 0, 0, 0);
        for (int i = 1; i < N; i++) do_op(1, i, 0, N - i);
        do_op(7, 0, 0, 0);
        wait_idle(1'b0, nb, nd);
        chk("sort_done_cnt", nd, 1);
        for (int i = 0; i < N; i++) rd_chk(i, i);

        // Same preload, REVERSE then ROT_UP.
        do_op(1, 0, 0, 0);
        for (int i = 1; i < N; i++) do_op(1, i, 0, N - i);
        do_op(6, 0, 0, 0);
        wait_idle(1'b0, nb, nd);
        chk("rev_busy_cycles", nb, 4);
        chk("rev_done_cnt", nd, 1);
        for (int i = 0; i < N; i++) rd_chk(i, (i + 1) % N);
        do_op(3, 0, 0, 0);
        for (int i = 0; i < N; i++) rd_chk(i, i);

        // Already sorted: one clean 7-compare pass.
        do_op(7, 0, 0, 0);
        wait_idle(1'b0, nb, nd);
        chk("sorted_busy_cycles", nb, 7);
        for (int i = 0; i < N; i++) rd_chk(i, i);

        // ADD overflow.
        do_op(1, 2, 0, 200);
        do_op(1, 3, 0, 100);
        do_op(5, 2, 3, 0);
        rd_chk(2, OVF_EN ? 255 : 44);
        chk("ovf_lit", bus.ovf, OVF_EN ? 1 : 0);
        do_op(1, 4, 0, 1);
        chk("ovf_after_wr", bus.ovf, OVF_EN ? 1 : 0);

        // WRITE during SORT is dropped; SWAP a==b is a no-op that still completes.
        preload(70, -10);
        do_op(7, 0, 0, 0);
        wait_idle(1'b1, nb, nd);
        rd_chk(0, 0);
        rd_chk(7, 70);
        do_op(2, 5, 5, 0);
        chk("swap_same_done", bus.done, 1);
        rd_chk(5, 50);

        // Randomised traffic.
        for (int k = 0; k < 600; k++) begin
            bus.op       = 3'($urandom_range(0, 7));
            bus.addr_a   = AW'($urandom_range(0, N - 1));
            bus.addr_b   = AW'($urandom_range(0, N - 1));
            bus.wdata    = W'($urandom);
            bus.op_valid = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.op_valid = 1'b0;
        wait_idle(1'b0, nb, nd);

        // Reset in the 3rd busy cycle of a SORT.
        preload(70, -10);
        do_op(7, 0, 0, 0);
        tick();
        tick();
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_ready", bus.op_ready, 1);
        chk("abort_done", bus.done, 0);
        for (int i = 0; i < N; i++) rd_chk(i, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_done", bus.done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
